// File: rtl/sequenciador_pwm_pkg.sv
// sequenciador_pwm_pkg
// Shared definitions for the PWM width-code sequencer: FSM state
// encodings, width-code constants and the debug state-port width.
// Optional feature macro used by the top: SEQUENCIADOR_DB_EN.
package sequenciador_pwm_pkg;

    localparam int unsigned DB_ESTADO_W = 3;

    typedef logic [1:0] codigo_t;

    localparam codigo_t CODIGO_00 = 2'b00;
    localparam codigo_t CODIGO_01 = 2'b01;
    localparam codigo_t CODIGO_10 = 2'b10;
    localparam codigo_t CODIGO_11 = 2'b11;

    typedef enum logic [DB_ESTADO_W-1:0] {
        INICIAL  = 3'b000,
        SUBINDO  = 3'b001,
        DESCENDO = 3'b010,
        FIM      = 3'b011
    } estado_t;

endpackage

// File: rtl/sequenciador_pwm_if.sv
// sequenciador_pwm_if
// Control/status bundle between the sequencer and its controller.
//   iniciar  : start request
//   parar    : abort request
//   continuo : repeat sweep indefinitely (sampled at sweep end)
//   largura  : width code to the PWM generator
//   ocupado  : high while sweeping
//   fim      : one-cycle pulse at sequence end or abort
// master = controller side, slave = sequencer side.
interface sequenciador_pwm_if;
    import sequenciador_pwm_pkg::*;

    logic    iniciar;
    logic    parar;
    logic    continuo;
    codigo_t largura;
    logic    ocupado;
    logic    fim;

    modport master (
        output iniciar,
        output parar,
        output continuo,
        input  largura,
        input  ocupado,
        input  fim
    );

    modport slave (
        input  iniciar,
        input  parar,
        input  continuo,
        output largura,
        output ocupado,
        output fim
    );

endinterface

// File: rtl/sequenciador_pwm_contador_m.sv
// contador_m
// Modulo-M up counter, 32 bits wide.
//   clock    : system clock, rising edge
//   reset    : synchronous, active-low
//   habilita : count enable
//   limpa    : synchronous clear (priority over habilita)
//   fim      : high while enabled and at M-1, i.e. on the wrap cycle
// With M=1 the value stays at 0 and fim follows habilita.
module contador_m #(
    parameter int unsigned M = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic habilita,
    input  logic limpa,
    output logic fim
);
    import sequenciador_pwm_pkg::*;

    localparam logic [31:0] MAXIMO = 32'(M - 1);

    logic [31:0] valor;

    always_ff @(posedge clock) begin
        if (!reset) begin
            valor <= '0;
        end else if (limpa) begin
            valor <= '0;
        end else if (habilita) begin
            if (valor == MAXIMO) begin
                valor <= '0;
            end else begin
                valor <= valor + 32'd1;
            end
        end
    end

    assign fim = habilita && (valor == MAXIMO);

endmodule

// File: rtl/sequenciador_pwm.sv
// sequenciador_pwm
// Drives the PWM generator's width code through the sweep
// 00->01->10->11->10->01->00, each code held for periodos_por_passo
// PWM periods of conf_periodo clocks. Single-shot or continuous,
// abortable, with a one-cycle fim pulse at the end.
//   clock : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : sequenciador_pwm_if.slave (iniciar, parar, continuo in;
//           largura, ocupado, fim out, all registered)
// Optional (SEQUENCIADOR_DB_EN defined):
//   db_estado : current FSM state (3 bits)
//   db_passo  : current sweep position (2 bits)
module sequenciador_pwm
    import sequenciador_pwm_pkg::*;
#(
    parameter int unsigned conf_periodo       = 1250,
    parameter int unsigned periodos_por_passo = 4000
) (
    input  logic                   clock,
    input  logic                   reset,
    sequenciador_pwm_if.slave      bus
`ifdef SEQUENCIADOR_DB_EN
    ,
    output logic [DB_ESTADO_W-1:0] db_estado,
    output logic [1:0]             db_passo
`endif
);

    estado_t estado, estado_prox;
    codigo_t posicao, posicao_prox;
    codigo_t largura_prox;
    logic    ocupado_prox;
    logic    fim_prox;

    logic    ativo;
    logic    contagem_fim;
    logic    fim_passo;

    assign ativo = (estado == SUBINDO) || (estado == DESCENDO);

    // Counters run only while sweeping; an abort or any other state clears
    // them, so a fresh start always begins from a full step.
    contador_m #(
        .M (conf_periodo)
    ) u_contagem (
        .clock    (clock),
        .reset    (reset),
        .habilita (ativo && !bus.parar),
        .limpa    (!ativo || bus.parar),
        .fim      (contagem_fim)
    );

    // fim of the step counter is qualified by its enable, so it is the
    // end-of-step event itself.
    contador_m #(
        .M (periodos_por_passo)
    ) u_passo (
        .clock    (clock),
        .reset    (reset),
        .habilita (ativo && !bus.parar && contagem_fim),
        .limpa    (!ativo || bus.parar),
        .fim      (fim_passo)
    );

    always_comb begin
        estado_prox  = estado;
        posicao_prox = posicao;

        case (estado)
            INICIAL: begin
                if (bus.iniciar && !bus.parar) begin
                    estado_prox  = SUBINDO;
                    posicao_prox = CODIGO_00;
                end
            end
            SUBINDO: begin
                if (bus.parar) begin
                    estado_prox = FIM;
                end else if (fim_passo) begin
                    if (posicao == CODIGO_11) begin
                        estado_prox  = DESCENDO;
                        posicao_prox = CODIGO_10;
                    end else begin
                        posicao_prox = posicao + 2'd1;
                    end
                end
            end
            DESCENDO: begin
                if (bus.parar) begin
                    estado_prox = FIM;
                end else if (fim_passo) begin
                    if (posicao != CODIGO_00) begin
                        posicao_prox = posicao - 2'd1;
                    end else if (bus.continuo) begin
                        estado_prox  = SUBINDO;
                        posicao_prox = CODIGO_01;
                    end else begin
                        estado_prox = FIM;
                    end
                end
            end
            FIM: begin
                estado_prox = INICIAL;
            end
            default: begin
                estado_prox = INICIAL;
            end
        endcase

        // Outputs are decoded from the next state so they register in step
        // with the state itself.
        ocupado_prox = (estado_prox == SUBINDO) || (estado_prox == DESCENDO);
        largura_prox = ocupado_prox ? posicao_prox : CODIGO_00;
        fim_prox     = (estado_prox == FIM);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado      <= INICIAL;
            posicao     <= CODIGO_00;
            bus.largura <= CODIGO_00;
            bus.ocupado <= 1'b0;
            bus.fim     <= 1'b0;
        end else begin
            estado      <= estado_prox;
            posicao     <= posicao_prox;
            bus.largura <= largura_prox;
            bus.ocupado <= ocupado_prox;
            bus.fim     <= fim_prox;
        end
    end

`ifdef SEQUENCIADOR_DB_EN
    assign db_estado = estado;
    assign db_passo  = posicao;
`endif

endmodule

// File: tb/tb_sequenciador_pwm.sv
// tb_sequenciador_pwm
// Self-checking bench for sequenciador_pwm with conf_periodo=4,
// periodos_por_passo=2 (8 clocks per step). Directed scenarios followed
// by random stimulus, all compared every cycle against a time-based
// model: elapsed cycles since start select the step, the step selects
// the code. Debug ports are checked when SEQUENCIADOR_DB_EN is defined.
module tb_sequenciador_pwm;

    localparam int unsigned CONF = 4;
    localparam int unsigned PPP  = 2;
    localparam int          P    = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    sequenciador_pwm_if bus ();

`ifdef SEQUENCIADOR_DB_EN
    logic [2:0] db_estado;
    logic [1:0] db_passo;
`endif

    sequenciador_pwm #(
        .conf_periodo       (CONF),
        .periodos_por_passo (PPP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus)
`ifdef SEQUENCIADOR_DB_EN
        ,
        .db_estado (db_estado),
        .db_passo  (db_passo)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int erros  = 0;

    task automatic verifica(input string tag, input logic [7:0] obs, input logic [7:0] esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s obs=%0h esp=%0h t=%0t", tag, obs, esp, $time);
        end
    endtask

    // Reference model state
    bit         m_busy = 1'b0;
    bit         m_fim  = 1'b0;
    int         m_e    = 0;
    logic [1:0] m_code = 2'd0;

    // Step 0 is 00; afterwards the sweep repeats 01,10,11,10,01,00.
    function automatic logic [1:0] codigo_do_passo(input int s);
        logic [1:0] tab [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
        if (s == 0) return 2'd0;
        return tab[(s - 1) % 6];
    endfunction

    function automatic logic [2:0] estado_esperado();
        int s;
        if (m_fim) return 3'd3;
        if (!m_busy) return 3'd0;
        s = m_e / P;
        if (s == 0) return 3'd1;
        return (((s - 1) % 6) < 3) ? 3'd1 : 3'd2;
    endfunction

    task automatic modelo_borda();
        int s;
        if (!reset) begin
            m_busy = 1'b0;
            m_fim  = 1'b0;
            m_code = 2'd0;
        end else if (m_fim) begin
            m_fim = 1'b0;
        end else if (m_busy) begin
            if (bus.parar) begin
                m_busy = 1'b0;
                m_fim  = 1'b1;
                m_code = 2'd0;
            end else begin
                m_e++;
                if (m_e % P == 0) begin
                    s = m_e / P;
                    if (s >= 7 && codigo_do_passo(s - 1) == 2'd0 && !bus.continuo) begin
                        m_busy = 1'b0;
                        m_fim  = 1'b1;
                        m_code = 2'd0;
                    end else begin
                        m_code = codigo_do_passo(s);
                    end
                end
            end
        end else if (bus.iniciar && !bus.parar) begin
            m_busy = 1'b1;
            m_e    = 0;
            m_code = 2'd0;
        end
    endtask

    task automatic ciclo();
        @(posedge clock);
        modelo_borda();
        #1;
        verifica("largura", {6'd0, bus.largura}, {6'd0, m_code});
        verifica("ocupado", {7'd0, bus.ocupado}, {7'd0, m_busy});
        verifica("fim",     {7'd0, bus.fim},     {7'd0, m_fim});
`ifdef SEQUENCIADOR_DB_EN
        verifica("db_estado", {5'd0, db_estado}, {5'd0, estado_esperado()});
        if (m_busy || !reset) begin
            verifica("db_passo", {6'd0, db_passo}, {6'd0, m_code});
        end
`endif
    endtask

    task automatic ciclos(input int n);
        for (int i = 0; i < n; i++) ciclo();
    endtask

    task automatic pulso_iniciar();
        bus.iniciar = 1'b1;
        ciclo();
        bus.iniciar = 1'b0;
    endtask

    initial begin
        bus.iniciar  = 1'b0;
        bus.parar    = 1'b0;
        bus.continuo = 1'b0;

        // Reset held, then released with idle inputs
        reset = 1'b0;
        ciclos(3);
        reset = 1'b1;
        ciclos(3);

        // Single sweep, with an ignored iniciar while busy
        pulso_iniciar();
        ciclos(9);
        pulso_iniciar();
        ciclos(55);

        // Continuous sweep for more than 20 steps, then let it finish
        bus.continuo = 1'b1;
        pulso_iniciar();
        ciclos(160);
        bus.continuo = 1'b0;
        ciclos(60);

        // Abort while at the top code, then a fresh full sweep
        pulso_iniciar();
        ciclos(26);
        bus.parar = 1'b1;
        ciclo();
        bus.parar = 1'b0;
        ciclos(4);
        pulso_iniciar();
        ciclos(60);

        // iniciar and parar together while idle
        bus.iniciar = 1'b1;
        bus.parar   = 1'b1;
        ciclos(2);
        bus.iniciar = 1'b0;
        bus.parar   = 1'b0;
        ciclos(3);

        // Reset mid-sweep
        pulso_iniciar();
        ciclos(19);
        reset = 1'b0;
        ciclo();
        reset = 1'b1;
        ciclos(5);

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 199) != 0);
            bus.iniciar  = ($urandom_range(0, 7) == 0);
            bus.parar    = ($urandom_range(0, 79) == 0);
            bus.continuo = ($urandom_range(0, 1) == 1);
            ciclo();
        end

        $display("CHECKS %0d ERRORS %0d", checks, erros);
        $finish;
    end

endmodule

// File: doc/sequenciador_pwm.md
Name: sequenciador_pwm

Overview:
- Upstream stage of the PWM generator. Drives its 2-bit `largura` width-code input through a timed sweep: 00→01→10→11→10→01→00.
- Code changes occur only on PWM-period boundaries, so each code is held for a whole number of PWM periods.
- Supports single-sweep and continuous modes, abort via `parar`, and a one-cycle `fim` completion pulse.

Parameters:
- conf_periodo, 1250: PWM period in clock cycles; must equal the PWM generator's period setting.
- periodos_por_passo, 4000: PWM periods each code is held (4000 × 25 µs = 100 ms at 50 MHz).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- iniciar  in  1  start request, sampled each clock.
- parar  in  1  abort request.
- continuo  in  1  1 = repeat sweep indefinitely; sampled only at sweep end.
- largura  out  2  width code to the PWM generator; registered.
- ocupado  out  1  high while sweeping.
- fim  out  1  one-cycle pulse when the sequence ends or is aborted.

Behaviour:
- All outputs are registered. Reset has priority over every other input.
- Reset (reset=0 at an edge) values: state INICIAL, largura=00, ocupado=0, fim=0, both counters=0, posicao=00.
- Counters:
  - contagem counts 0..conf_periodo-1.
  - passo counts 0..periodos_por_passo-1 and advances when contagem wraps.
  - fim_passo = (contagem==conf_periodo-1) && (passo==periodos_por_passo-1).
  - Both counters are cleared on start and held at 0 outside SUBINDO/DESCENDO.
- State INICIAL:
  - largura=00, ocupado=0.
  - iniciar=1 && parar=0 → SUBINDO, posicao=00, counters=0.
  - parar=1 wins over a simultaneous iniciar: the block stays in INICIAL.
- State SUBINDO (ocupado=1, largura=posicao):
  - On fim_passo with posicao<11: posicao+1.
  - On fim_passo with posicao==11: → DESCENDO, posicao=10.
- State DESCENDO (ocupado=1, largura=posicao):
  - On fim_passo with posicao>00: posicao-1.
  - On fim_passo with posicao==00 and continuo=1: → SUBINDO, posicao=01.
  - On fim_passo with posicao==00 and continuo=0: → FIM.
- State FIM: lasts exactly one cycle; fim=1, largura=00, ocupado=0; then → INICIAL.
- parar=1 in SUBINDO or DESCENDO: → FIM at the next edge. largura=00 from that edge. parar has priority over a coincident fim_passo.
- iniciar while in SUBINDO, DESCENDO or FIM is ignored; no restart.
- Timing:
  - iniciar sampled at edge E0 → largura=00 held until E(P), where P = conf_periodo × periodos_por_passo.
  - Each code is held exactly P cycles.
  - A single sweep is 7 steps; fim is high during cycle [7P, 7P+1) after E0.
- Reset mid-sweep: at the next edge, all outputs return to reset values, with no fim pulse.
- Counter widths are 32 bits. Parameters must be ≥1; with periodos_por_passo=1, passo stays at 0.

Optional Feature:
- Macro SEQUENCIADOR_DB_EN.
- Defined: adds ports db_estado (out, 3 bits: INICIAL=000, SUBINDO=001, DESCENDO=010, FIM=011) and db_passo (out, 2 bits = posicao). Both reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package: state encodings (INICIAL, SUBINDO, DESCENDO, FIM), width-code constants (CODIGO_00..CODIGO_11), and the db_estado width.
- One natural sub-module: contador_m, a parameterised modulo-M counter with synchronous active-low reset, enable, clear and a `fim` wrap output. It is instantiated twice: contagem (M=conf_periodo) and passo (M=periodos_por_passo).

Test Plan (conf_periodo=4, periodos_por_passo=2, so P=8):
- Reset: hold reset=0 for 3 cycles → largura=00, ocupado=0, fim=0. Release with inputs idle → outputs unchanged.
- Single sweep: iniciar pulse at E0, continuo=0 → largura 00,01,10,11,10,01,00, each held 8 cycles. fim=1 for exactly the one cycle following E56. ocupado=1 through cycle 56 and 0 after.
- Continuous sweep: continuo=1, iniciar → after descending 00 (E56), largura=01. Run 20 steps → no fim pulse, ocupado stays 1.
- Abort: parar asserted at E26 (posicao=11) → largura=00 and fim=1 from E27 for one cycle, INICIAL at E28. A new iniciar restarts from 00 with full 8-cycle steps.
- Priority and ignored inputs: iniciar at E10 while busy → sequence timing unchanged. iniciar and parar together in INICIAL → stays in INICIAL, ocupado=0.
- Reset mid-sweep: reset=0 at E20 → largura=00, ocupado=0 after E20, no fim pulse. With SEQUENCIADOR_DB_EN defined → db_estado=000, db_passo=00.
